// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the fractional baud generator.
//   - Default widths, oversample ratio and reset divisor.
//   - baud_cfg_t: the {integer, fractional} divisor pair at default widths.
//   - DEF_CFG: the divisor the block comes out of reset with.
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int N_DEF        = 11;   // integer divisor / count width
    localparam int F_DEF        = 4;    // fractional divisor width (1/2^F units)
    localparam int OVS_DEF      = 16;   // ticks per bit_tick
    localparam int DEF_INT_DEF  = 326;  // integer divisor after reset
    localparam int DEF_FRAC_DEF = 0;    // fractional divisor after reset

    typedef struct packed {
        logic [N_DEF-1:0] div_int;
        logic [F_DEF-1:0] div_frac;
    } baud_cfg_t;

    localparam baud_cfg_t DEF_CFG = '{
        div_int:  N_DEF'(DEF_INT_DEF),
        div_frac: F_DEF'(DEF_FRAC_DEF)
    };

endpackage

// File: rtl/frac_accumulator.sv
// ---------------------------------------------------------------------------
// frac_accumulator
// Fractional phase accumulator. On every step strobe the fractional divisor
// is added into an F-bit accumulator; the carry out of that addition is kept
// as ext and lengthens the following period by one cycle.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   step      in   one-cycle strobe: accumulate div_frac (period wrap)
//   clear     in   synchronous clear of acc and ext (wins over step)
//   div_frac  in   F-bit fractional divisor
//   ext       out  1 when the current period is one cycle longer
// ---------------------------------------------------------------------------
module frac_accumulator #(
    parameter int F = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         clear,
    input  logic [F-1:0] div_frac,
    output logic         ext
);

    logic [F-1:0] acc_reg;
    logic         ext_reg;
    logic [F:0]   sum_next;

    // F+1-bit sum: the MSB is the carry that becomes next period's ext.
    assign sum_next = {1'b0, acc_reg} + {1'b0, div_frac};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
            ext_reg <= 1'b0;
        end else if (clear) begin
            acc_reg <= '0;
            ext_reg <= 1'b0;
        end else if (step) begin
            {ext_reg, acc_reg} <= sum_next;
        end
    end

    assign ext = ext_reg;

endmodule

// File: rtl/frac_baud_gen.sv
// ---------------------------------------------------------------------------
// frac_baud_gen
// Fractional baud-rate generator. A counter runs 0..L-1 where
// L = max(div_int,2) + ext; ext comes from a fractional accumulator so the
// average period is div_int + div_frac/2^F cycles. Every OVS ticks a
// bit_tick is produced. A new divisor is taken through a valid/ready
// handshake into a shadow register and applied only at a period boundary
// (or immediately when the counter is stopped), so a running period is never
// cut short or stretched.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   en         in   count enable; low freezes counter/accumulator/oversample
//   clr        in   synchronous restart of counter, accumulator, os count
//   cfg_valid  in   new divisor offered
//   cfg_int    in   offered integer divisor (N bits)
//   cfg_frac   in   offered fractional divisor (F bits)
//   cfg_ready  out  block can accept a divisor (no update pending)
//   tick       out  one-cycle sample tick (the wrap cycle)
//   bit_tick   out  one-cycle tick on the last of every OVS ticks
//   q          out  current count
//   os_q       out  current oversample index
// ---------------------------------------------------------------------------
module frac_baud_gen
    import baud_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int F        = F_DEF,
    parameter int OVS      = OVS_DEF,
    parameter int DEF_INT  = int'(DEF_CFG.div_int),
    parameter int DEF_FRAC = int'(DEF_CFG.div_frac)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    cfg_valid,
    input  logic [N-1:0]            cfg_int,
    input  logic [F-1:0]            cfg_frac,
    output logic                    cfg_ready,
    output logic                    tick,
    output logic                    bit_tick,
    output logic [N-1:0]            q,
    output logic [$clog2(OVS)-1:0]  os_q
);

    localparam int             OSW     = $clog2(OVS);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVS - 1);
    localparam logic [N:0]     MIN_DIV = (N+1)'(2);
    localparam logic [N:0]     ONE_W   = (N+1)'(1);

    // Active and shadow divisors plus handshake state
    logic [N-1:0]   div_int_reg;
    logic [F-1:0]   div_frac_reg;
    logic [N-1:0]   shadow_int_reg;
    logic [F-1:0]   shadow_frac_reg;
    logic           pending_reg;

    // Counters
    logic [N-1:0]   q_reg;
    logic [OSW-1:0] os_reg;

    // Combinational control
    logic           ext;
    logic [N:0]     d_eff;
    logic [N:0]     period_len;
    logic           at_last;
    logic           wrap;
    logic           apply;
    logic           capture;
    logic           acc_clear;

    // Period length and end-of-period detect are computed one bit wider than
    // the count so that div_int = 2^N-1 with ext = 1 does not overflow.
    always_comb begin
        d_eff      = (div_int_reg < N'(2)) ? MIN_DIV : {1'b0, div_int_reg};
        period_len = d_eff + {{N{1'b0}}, ext};
        at_last    = ({1'b0, q_reg} == (period_len - ONE_W));
    end

    // A pending shadow lands on the wrap cycle while running; with the
    // counter stopped there is no period to protect, so it lands at once.
    always_comb begin
        wrap      = en & ~clr & at_last;
        apply     = pending_reg & (en ? at_last : 1'b1);
        capture   = cfg_valid & ~pending_reg;
        acc_clear = clr | apply;
    end

    // ----------------------------------------------------------------------
    // Configuration handshake: shadow capture and apply
    // ----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_int_reg     <= N'(DEF_INT);
            div_frac_reg    <= F'(DEF_FRAC);
            shadow_int_reg  <= N'(DEF_INT);
            shadow_frac_reg <= F'(DEF_FRAC);
            pending_reg     <= 1'b0;
        end else begin
            // capture needs pending=0 and apply needs pending=1, so the two
            // never coincide.
            if (capture) begin
                shadow_int_reg  <= cfg_int;
                shadow_frac_reg <= cfg_frac;
                pending_reg     <= 1'b1;
            end
            if (apply) begin
                div_int_reg  <= shadow_int_reg;
                div_frac_reg <= shadow_frac_reg;
                pending_reg  <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------------
    // Integer period counter
    // ----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else if (clr || apply) begin
            q_reg <= '0;
        end else if (en) begin
            if (at_last) begin
                q_reg <= '0;
            end else begin
                q_reg <= q_reg + N'(1);
            end
        end
    end

    // ----------------------------------------------------------------------
    // Oversample counter: advances on every tick, untouched by apply
    // ----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_reg <= '0;
        end else if (clr) begin
            os_reg <= '0;
        end else if (wrap) begin
            if (os_reg == OS_LAST) begin
                os_reg <= '0;
            end else begin
                os_reg <= os_reg + OSW'(1);
            end
        end
    end

    // ----------------------------------------------------------------------
    // Fractional accumulator
    // ----------------------------------------------------------------------
    frac_accumulator #(
        .F (F)
    ) u_frac_accumulator (
        .clk      (clk),
        .reset    (reset),
        .step     (wrap),
        .clear    (acc_clear),
        .div_frac (div_frac_reg),
        .ext      (ext)
    );

    // ----------------------------------------------------------------------
    // Outputs
    // ----------------------------------------------------------------------
    assign tick      = wrap;
    assign bit_tick  = wrap & (os_reg == OS_LAST);
    assign cfg_ready = ~pending_reg;
    assign q         = q_reg;
    assign os_q      = os_reg;

endmodule

// File: tb/tb_frac_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_frac_baud_gen
// Directed plus randomized stimulus for frac_baud_gen. The reference model
// tracks the position inside the current period and the number of periods
// since the last restart; the length of period k is derived in closed form:
//   L(0) = D,  L(k) = D + floor(k*f/2^F) - floor((k-1)*f/2^F)
// ---------------------------------------------------------------------------
module tb_frac_baud_gen;

    localparam int N   = 11;
    localparam int F   = 4;
    localparam int OVS = 16;
    localparam int OSW = $clog2(OVS);

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           clr;
    logic           cfg_valid;
    logic [N-1:0]   cfg_int;
    logic [F-1:0]   cfg_frac;
    logic           cfg_ready;
    logic           tick;
    logic           bit_tick;
    logic [N-1:0]   q;
    logic [OSW-1:0] os_q;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_int, m_frac, s_int, s_frac;
    int m_pend, m_pos, m_k, m_os;

    frac_baud_gen #(
        .N        (N),
        .F        (F),
        .OVS      (OVS),
        .DEF_INT  (326),
        .DEF_FRAC (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .cfg_valid (cfg_valid),
        .cfg_int   (cfg_int),
        .cfg_frac  (cfg_frac),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .bit_tick  (bit_tick),
        .q         (q),
        .os_q      (os_q)
    );

    always #5 clk = ~clk;

    function automatic int plen();
        int d;
        d = (m_int < 2) ? 2 : m_int;
        if (m_k == 0) return d;
        return d + ((m_k * m_frac) >> F) - (((m_k - 1) * m_frac) >> F);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_defaults();
        m_int  = 326; m_frac = 0;
        s_int  = 326; s_frac = 0;
        m_pend = 0;   m_pos  = 0; m_k = 0; m_os = 0;
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance model.
    task automatic step(input bit e, input bit c, input bit v, input int ci, input int cf);
        int pl;
        bit end_p, exp_tick, apply, cap;
        en = e; clr = c; cfg_valid = v;
        cfg_int = ci[N-1:0]; cfg_frac = cf[F-1:0];
        #1;
        pl       = plen();
        end_p    = (m_pos == pl - 1);
        exp_tick = e && !c && end_p;
        check("q",         32'(q),         32'(m_pos));
        check("os_q",      32'(os_q),      32'(m_os));
        check("tick",      32'(tick),      32'(exp_tick));
        check("bit_tick",  32'(bit_tick),  32'(exp_tick && (m_os == OVS - 1)));
        check("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
        apply = (m_pend != 0) && (e ? end_p : 1'b1);
        cap   = v && (m_pend == 0);
        if (cap)
            $display("cfg accepted int=%0d frac=%0d at q=%0d t=%0t", ci & ((1 << N) - 1), cf & ((1 << F) - 1), m_pos, $time);
        @(posedge clk);
        if (c) m_os = 0;
        else if (exp_tick) m_os = (m_os + 1) % OVS;
        if (apply) begin
            m_int = s_int; m_frac = s_frac; m_pend = 0;
        end
        if (c || apply) begin
            m_pos = 0; m_k = 0;
        end else if (e) begin
            if (end_p) begin m_pos = 0; m_k++; end
            else m_pos++;
        end
        if (cap) begin
            m_pend = 1;
            s_int  = ci & ((1 << N) - 1);
            s_frac = cf & ((1 << F) - 1);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit e);
        repeat (n) step(e, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en = 1'b1; clr = 1'b0; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0;
        #1;
        model_defaults();
        check("rst_q",         32'(q),         32'd0);
        check("rst_os_q",      32'(os_q),      32'd0);
        check("rst_tick",      32'(tick),      32'd0);
        check("rst_bit_tick",  32'(bit_tick),  32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("reset released t=%0t", $time);
    endtask

    task automatic configure(input int ci, input int cf);
        // Stopped counter: the shadow applies on the cycle after capture.
        step(1'b0, 1'b0, 1'b1, ci, cf);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0; clr = 1'b0; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0;
        @(negedge clk);
        do_reset();

        // Default divisor: first tick at q=325
        run(330, 1'b1);

        // int=5 frac=0: tick every 5 cycles
        configure(5, 0);
        run(30, 1'b1);

        // int=5 frac=8: spacings 5,5,6,5,6,...
        configure(5, 8);
        run(60, 1'b1);

        // int=2: bit_tick every 32 cycles
        configure(2, 0);
        run(100, 1'b1);

        // Divisor update offered mid-period must wait for the wrap
        configure(5, 0);
        for (int i = 0; i < 20 && m_pos != 2; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
        check("reach_q2", 32'(q), 32'd2);
        step(1'b1, 1'b0, 1'b1, 7, 0);
        run(25, 1'b1);

        // Freeze for 10 cycles mid-period, then resume
        for (int i = 0; i < 20 && m_pos != 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
        run(10, 1'b0);
        run(20, 1'b1);

        // clr coinciding with the wrap cycle
        configure(5, 8);
        run(13, 1'b1);
        for (int i = 0; i < 20 && m_pos != plen() - 1; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        run(20, 1'b1);

        // div_int 0 and 1 behave as 2
        configure(0, 0);
        run(12, 1'b1);
        configure(1, 15);
        run(12, 1'b1);

        // Largest divisor with carry: no overflow in period length
        configure((1 << N) - 1, 15);
        run(4200, 1'b1);

        // Reset with an update pending restores the defaults
        configure(9, 3);
        step(1'b1, 1'b0, 1'b1, 4, 0);
        run(3, 1'b1);
        @(negedge clk);
        do_reset();
        run(330, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frac_baud_gen.md
FRAC_BAUD_GEN -- requirements
Module: frac_baud_gen

Interface
REQ-001 Parameter N, default 11: width of the integer divisor and of the count output.
REQ-002 Parameter F, default 4: width of the fractional divisor, in units of 1/2^F.
REQ-003 Parameter OVS, default 16: oversample ratio, i.e. ticks per bit_tick (must be >= 2).
REQ-004 Parameter DEF_INT, default 326, and parameter DEF_FRAC, default 0: divisor loaded at reset.
REQ-005 clk  in  1  single clock for the whole block; all registers on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
REQ-007 en  in  1  count enable; low freezes all state.
REQ-008 clr  in  1  synchronous restart of the counter, accumulator and oversample count.
REQ-009 cfg_valid  in  1  new divisor offered.
REQ-010 cfg_int  in  N  offered integer divisor.
REQ-011 cfg_frac  in  F  offered fractional divisor.
REQ-012 cfg_ready  out  1  block can accept a divisor.
REQ-013 tick  out  1  one-cycle sample tick.
REQ-014 bit_tick  out  1  one-cycle tick, once every OVS ticks.
REQ-015 q  out  N  current count.
REQ-016 os_q  out  clog2(OVS)  current oversample index.

Function
REQ-017 Effective integer divisor D = max(div_int, 2); a div_int of 0 or 1 shall behave as 2.
REQ-018 Period length L = D + ext, where ext is a 1-bit register.
REQ-019 q shall count 0..L-1 and then wrap to 0.
REQ-020 tick = en & ~clr & (q == L-1), combinational; the tick cycle is the wrap cycle.
REQ-021 On each wrap, {carry, acc} <= acc + div_frac (F+1-bit sum), and ext <= carry for the following period.
REQ-022 Example: with D=5 and frac=8 (F=4), period lengths shall run 5,5,6,5,6,...
REQ-023 os counter shall increment on each tick and wrap at OVS-1.
REQ-024 bit_tick = tick & (os_q == OVS-1).
REQ-025 en low: q, acc, ext and os hold; tick and bit_tick are 0; the config handshake still operates.
REQ-026 clr high: next cycle q=0, acc=0, ext=0, os=0; clr has priority over en and wrap; no tick in the clr cycle.
REQ-027 cfg_ready = ~pending.
REQ-028 When cfg_valid & cfg_ready, the block shall capture cfg_int and cfg_frac into shadow registers and set pending=1.
REQ-029 A pending shadow shall be applied in the wrap cycle when en=1, or in the next cycle when en=0.
REQ-030 On apply: active divisor <= shadow, acc <= 0, ext <= 0, q <= 0, pending <= 0; os is unchanged.
REQ-031 If clr and apply occur in the same cycle, both shall take effect.
REQ-032 A new divisor shall never truncate or extend the period that is in progress when en=1.
REQ-033 Arithmetic: q compares against L with N+1-bit width; there shall be no overflow when div_int = 2^N-1 and ext=1.

Reset
REQ-034 Reset state: q=0, os=0, acc=0, ext=0, pending=0, active divisor = DEF_INT/DEF_FRAC, shadow = defaults.
REQ-035 During reset, tick=0, bit_tick=0 and cfg_ready=1.
REQ-036 Reset asserted mid-period or with an update pending shall discard the shadow and restore the defaults.

Structure
REQ-037 Shared package baud_pkg shall hold the defaults of N, F, OVS, DEF_INT and DEF_FRAC.
REQ-038 baud_pkg shall also hold the typedef baud_cfg_t {div_int, div_frac}.
REQ-039 One sub-module, frac_accumulator, shall hold acc and ext and take div_frac, a step strobe and a clear; the integer counter stays in the top module.

Verification
REQ-040 Reset, cfg int=5 frac=0, en=1 -> tick every 5 cycles; q runs 0..4.
REQ-041 int=5 frac=8, F=4 -> tick spacings 5,5,6,5,6; 11 cycles per 2 ticks on average.
REQ-042 OVS=16, int=2 -> bit_tick every 32 cycles, coincident with the tick where os_q=15.
REQ-043 Offer int=7 at q=2 of a D=5 period -> cfg_ready=0 until wrap; the current period stays 5; the next period is 7; cfg_ready returns to 1.
REQ-044 en=0 for 10 cycles mid-period -> q frozen, no tick; the period resumes with the original remaining count.
REQ-045 clr together with the wrap cycle -> no tick; q=0 next cycle; os=0; acc=0.
